// File: rtl/itype_stim_sequencer_pkg.sv
// Shared constants, state encoding and the I-type encoder for the sodor5 stimulus sequencer.
package sodor5_stim_pkg;

    localparam logic [6:0]  OPC_OP_IMM    = 7'b0010011;
    localparam logic [31:0] NOP_INSTR     = 32'h00000013;
    localparam logic [2:0]  F3_SLLI       = 3'd1;
    localparam logic [2:0]  F3_SRXI       = 3'd5;
    localparam logic [11:0] IMM_MASK_SRXI = 12'h41F;
    localparam logic [11:0] IMM_MASK_SLLI = 12'h01F;
    localparam logic [31:0] LFSR_MASK     = 32'h80200003;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } stim_state_t;

    // Shift immediates keep only legal shamt bits (plus bit 30 for SRAI).
    function automatic logic [31:0] encode_itype(input logic [31:0] l);
        logic [11:0] imm;
        logic [2:0]  f3;
        imm = l[31:20];
        f3  = l[14:12];
        if (f3 == F3_SRXI) begin
            imm = imm & IMM_MASK_SRXI;
        end else if (f3 == F3_SLLI) begin
            imm = imm & IMM_MASK_SLLI;
        end
        return {imm, l[19:15], f3, l[11:7], OPC_OP_IMM};
    endfunction

endpackage

// File: rtl/itype_stim_sequencer_if.sv
// Instruction-memory request/response bundle between the core and the stimulus sequencer.
interface itype_stim_sequencer_if;

    logic        imem_req_valid;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_bits_data;

    modport master (
        output imem_req_valid,
        input  imem_resp_valid,
        input  imem_resp_bits_data
    );

    modport slave (
        input  imem_req_valid,
        output imem_resp_valid,
        output imem_resp_bits_data
    );

endinterface

// File: rtl/itype_stim_sequencer_lfsr32_galois.sv
// 32-bit Galois LFSR that steps only when asked; a zero seed is promoted to 1 so it never locks up.
module lfsr32_galois
    import sodor5_stim_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    input  logic [31:0] seed,
    output logic [31:0] value
);

    logic [31:0] seed_nz;

    assign seed_nz = (seed == 32'd0) ? 32'd1 : seed;

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= seed_nz;
        end else if (advance) begin
            value <= (value >> 1) ^ (value[0] ? LFSR_MASK : 32'd0);
        end
    end

endmodule

// File: rtl/itype_stim_sequencer.sv
// Bounded, seed-repeatable I-type stimulus source answering the core's instruction fetches.
module itype_stim_sequencer
    import sodor5_stim_pkg::*;
#(
    parameter int unsigned NUM_INSTR     = 100,
    parameter int unsigned WARMUP_CYCLES = 3,
    parameter int unsigned DRAIN_CYCLES  = 5,
    parameter logic [31:0] SEED          = 32'd528
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    itype_stim_sequencer_if.slave         imem,
    output logic                          busy,
    output logic                          done,
    output logic [15:0]                   instr_count
);

    localparam logic [31:0] WARMUP_LAST = 32'(WARMUP_CYCLES - 1);
    localparam logic [31:0] DRAIN_LAST  = 32'(DRAIN_CYCLES - 1);
    localparam logic [15:0] INSTR_LAST  = 16'(NUM_INSTR - 1);

    stim_state_t state, state_next;
    logic [31:0] phase_cnt, phase_next;
    logic [15:0] count_next;
    logic [31:0] lfsr_value;
    logic [31:0] word;
    logic        advance;
    logic        req;

    assign req = imem.imem_req_valid;

    lfsr32_galois u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (advance),
        .seed    (SEED),
        .value   (lfsr_value)
    );

    // Everything except IDLE's start moves only on an accepted fetch, so stalls never skip or repeat.
    always_comb begin
        state_next = state;
        phase_next = phase_cnt;
        count_next = instr_count;
        advance    = 1'b0;
        word       = NOP_INSTR;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_WARMUP;
                    phase_next = 32'd0;
                end
            end
            ST_WARMUP: begin
                if (req) begin
                    if (phase_cnt == WARMUP_LAST) begin
                        state_next = ST_RUN;
                        phase_next = 32'd0;
                    end else begin
                        phase_next = phase_cnt + 32'd1;
                    end
                end
            end
            ST_RUN: begin
                if (req) begin
                    word       = encode_itype(lfsr_value);
                    advance    = 1'b1;
                    count_next = instr_count + 16'd1;
                    if (instr_count == INSTR_LAST) begin
                        state_next = ST_DRAIN;
                        phase_next = 32'd0;
                    end
                end
            end
            ST_DRAIN: begin
                if (req) begin
                    if (phase_cnt == DRAIN_LAST) begin
                        state_next = ST_DONE;
                        phase_next = 32'd0;
                    end else begin
                        phase_next = phase_cnt + 32'd1;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_DONE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Response data holds its last value whenever no fetch is presented.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                    <= ST_IDLE;
            phase_cnt                <= 32'd0;
            instr_count              <= 16'd0;
            imem.imem_resp_valid     <= 1'b0;
            imem.imem_resp_bits_data <= NOP_INSTR;
        end else begin
            state                <= state_next;
            phase_cnt            <= phase_next;
            instr_count          <= count_next;
            imem.imem_resp_valid <= req;
            if (req) begin
                imem.imem_resp_bits_data <= word;
            end
        end
    end

    assign busy = (state == ST_WARMUP) || (state == ST_RUN) || (state == ST_DRAIN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_itype_stim_sequencer.sv
// Randomized fetch-pattern bench for itype_stim_sequencer against a fetch-index reference model.
module tb_itype_stim_sequencer;

    localparam int unsigned A_N    = 100;
    localparam int unsigned A_W    = 3;
    localparam int unsigned A_D    = 5;
    localparam logic [31:0] A_SEED = 32'd528;
    localparam logic [31:0] NOP    = 32'h00000013;

    logic clk = 1'b0;
    logic reset;
    logic start_a, req_a, start_g, req_g;

    always #5 clk = ~clk;

    itype_stim_sequencer_if ifa ();
    itype_stim_sequencer_if ifb ();
    itype_stim_sequencer_if ifc0 ();
    itype_stim_sequencer_if ifc1 ();
    itype_stim_sequencer_if ifc2 ();

    assign ifa.imem_req_valid  = req_a;
    assign ifb.imem_req_valid  = req_g;
    assign ifc0.imem_req_valid = req_g;
    assign ifc1.imem_req_valid = req_g;
    assign ifc2.imem_req_valid = req_g;

    logic        busy_a, done_a, busy_b, done_b, busy_c0, done_c0, busy_c1, done_c1, busy_c2, done_c2;
    logic [15:0] cnt_a, cnt_b, cnt_c0, cnt_c1, cnt_c2;

    itype_stim_sequencer #(.NUM_INSTR(A_N), .WARMUP_CYCLES(A_W), .DRAIN_CYCLES(A_D), .SEED(A_SEED)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .imem(ifa),
        .busy(busy_a), .done(done_a), .instr_count(cnt_a));

    itype_stim_sequencer #(.NUM_INSTR(2), .WARMUP_CYCLES(1), .DRAIN_CYCLES(1), .SEED(32'd0)) dut_b (
        .clk(clk), .reset(reset), .start(start_g), .imem(ifb),
        .busy(busy_b), .done(done_b), .instr_count(cnt_b));

    itype_stim_sequencer #(.NUM_INSTR(1), .WARMUP_CYCLES(1), .DRAIN_CYCLES(1), .SEED(32'hFFF05000)) dut_c0 (
        .clk(clk), .reset(reset), .start(start_g), .imem(ifc0),
        .busy(busy_c0), .done(done_c0), .instr_count(cnt_c0));

    itype_stim_sequencer #(.NUM_INSTR(1), .WARMUP_CYCLES(1), .DRAIN_CYCLES(1), .SEED(32'hFFF01000)) dut_c1 (
        .clk(clk), .reset(reset), .start(start_g), .imem(ifc1),
        .busy(busy_c1), .done(done_c1), .instr_count(cnt_c1));

    itype_stim_sequencer #(.NUM_INSTR(1), .WARMUP_CYCLES(1), .DRAIN_CYCLES(1), .SEED(32'hFFF00000)) dut_c2 (
        .clk(clk), .reset(reset), .start(start_g), .imem(ifc2),
        .busy(busy_c2), .done(done_c2), .instr_count(cnt_c2));

    int checks = 0;
    int passed = 0;

    // Reference model: position of each accepted fetch since start decides what is returned.
    bit          m_started;
    int unsigned m_k;
    int unsigned m_count;
    logic [31:0] m_lfsr;
    logic [31:0] m_data;
    logic        m_valid;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    endtask

    function automatic logic [31:0] modelLfsrNext(input logic [31:0] l);
        return (l >> 1) ^ (((l % 2) == 1) ? 32'h80200003 : 32'd0);
    endfunction

    function automatic logic [31:0] modelWord(input logic [31:0] l);
        int unsigned imm, rs1, f3, rd;
        imm = (l / 32'h100000) % 4096;
        rs1 = (l / 32'h8000) % 32;
        f3  = (l / 32'h1000) % 8;
        rd  = (l / 32'h80) % 32;
        if (f3 == 5) imm = imm & 32'h41F;
        if (f3 == 1) imm = imm & 32'h01F;
        return (imm * 32'h100000) + (rs1 * 32'h8000) + (f3 * 32'h1000) + (rd * 32'h80) + 32'h13;
    endfunction

    task automatic modelReset();
        m_started = 1'b0;
        m_k       = 0;
        m_count   = 0;
        m_lfsr    = (A_SEED == 32'd0) ? 32'd1 : A_SEED;
        m_data    = NOP;
        m_valid   = 1'b0;
    endtask

    task automatic modelStep(input bit rq, input bit st);
        m_valid = rq;
        if (rq) begin
            if (m_started && m_k >= A_W && m_k < A_W + A_N) begin
                m_data = modelWord(m_lfsr);
                m_lfsr = modelLfsrNext(m_lfsr);
                m_count++;
            end else begin
                m_data = NOP;
            end
            if (m_started) m_k++;
        end
        if (!m_started && st) begin
            m_started = 1'b1;
            m_k       = 0;
        end
    endtask

    // Drives one cycle of DUT A from a negedge, advances the model at the edge, then compares.
    task automatic applyStimulus(input bit rq, input bit st);
        bit fin;
        req_a   = rq;
        start_a = st;
        @(posedge clk);
        modelStep(rq, st);
        @(negedge clk);
        start_a = 1'b0;
        fin = m_started && (m_k >= A_W + A_N + A_D);
        checkOutput("a_valid", {31'd0, ifa.imem_resp_valid}, {31'd0, m_valid});
        checkOutput("a_data", ifa.imem_resp_bits_data, m_data);
        checkOutput("a_count", {16'd0, cnt_a}, m_count);
        checkOutput("a_busy", {31'd0, busy_a}, {31'd0, m_started && !fin});
        checkOutput("a_done", {31'd0, done_a}, {31'd0, fin});
    endtask

    logic [31:0] first_word;
    logic [31:0] exp_b  [4];
    logic [31:0] exp_c0 [4];
    logic [31:0] exp_c1 [4];
    logic [31:0] exp_c2 [4];

    initial begin
        bit stalled, poked, got_first;
        int budget;

        exp_b  = '{32'h00000013, 32'h00000013, 32'h80200013, 32'h00000013};
        exp_c0 = '{32'h00000013, 32'h41F05013, 32'h00000013, 32'h00000013};
        exp_c1 = '{32'h00000013, 32'h01F01013, 32'h00000013, 32'h00000013};
        exp_c2 = '{32'h00000013, 32'hFFF00013, 32'h00000013, 32'h00000013};

        reset = 1'b1; start_a = 1'b0; req_a = 1'b0; start_g = 1'b0; req_g = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_valid", {31'd0, ifa.imem_resp_valid}, 32'd0);
        checkOutput("rst_data", ifa.imem_resp_bits_data, NOP);
        checkOutput("rst_busy", {31'd0, busy_a}, 32'd0);
        checkOutput("rst_done", {31'd0, done_a}, 32'd0);
        checkOutput("rst_count", {16'd0, cnt_a}, 32'd0);
        reset = 1'b0;
        modelReset();

        // Fetches with no start: NOP answers, nothing counted.
        for (int i = 0; i < 10; i++) applyStimulus(($urandom % 2) == 1, 1'b0);

        // First run, aborted by reset at instr_count 37, with one 4-cycle stall and a stray start.
        applyStimulus(1'b0, 1'b1);
        stalled = 1'b0; poked = 1'b0; got_first = 1'b0; first_word = NOP; budget = 0;
        while (m_count < 37 && budget < 1000) begin
            if (!stalled && m_count == 20) begin
                stalled = 1'b1;
                for (int s = 0; s < 4; s++) applyStimulus(1'b0, 1'b0);
            end else if (!poked && m_count == 10) begin
                poked = 1'b1;
                applyStimulus($urandom_range(0, 3) != 0, 1'b1);
            end else begin
                applyStimulus($urandom_range(0, 3) != 0, 1'b0);
            end
            if (!got_first && m_count == 1) begin
                got_first  = 1'b1;
                first_word = m_data;
            end
            budget++;
        end
        checkOutput("reach_37", m_count, 32'd37);

        reset = 1'b1; req_a = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        checkOutput("abort_count", {16'd0, cnt_a}, 32'd0);
        checkOutput("abort_busy", {31'd0, busy_a}, 32'd0);
        checkOutput("abort_valid", {31'd0, ifa.imem_resp_valid}, 32'd0);
        checkOutput("abort_data", ifa.imem_resp_bits_data, NOP);

        // Fresh run to completion; the first RUN word must replay the aborted run's first word.
        applyStimulus(1'b0, 1'b1);
        budget = 0; got_first = 1'b0;
        while (m_k < A_W + A_N + A_D && budget < 2000) begin
            applyStimulus($urandom_range(0, 4) != 0, 1'b0);
            if (!got_first && m_count == 1) begin
                got_first = 1'b1;
                checkOutput("replay_first", ifa.imem_resp_bits_data, first_word);
            end
            budget++;
        end
        checkOutput("run_complete", m_k, A_W + A_N + A_D);
        checkOutput("final_done", {31'd0, done_a}, 32'd1);
        checkOutput("final_count", {16'd0, cnt_a}, A_N);

        // start in DONE is ignored and done is sticky.
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("done_sticky", {31'd0, done_a}, 32'd1);

        // Small-parameter instances: SEED=0 sequence and shift-immediate masking.
        reset = 1'b1; req_a = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        start_g = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_g = 1'b0;
        req_g   = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("b_valid%0d", c), {31'd0, ifb.imem_resp_valid}, 32'd1);
            checkOutput($sformatf("b_data%0d", c), ifb.imem_resp_bits_data, exp_b[c]);
            checkOutput($sformatf("c0_data%0d", c), ifc0.imem_resp_bits_data, exp_c0[c]);
            checkOutput($sformatf("c1_data%0d", c), ifc1.imem_resp_bits_data, exp_c1[c]);
            checkOutput($sformatf("c2_data%0d", c), ifc2.imem_resp_bits_data, exp_c2[c]);
            if (c == 2) begin
                checkOutput("c0_done", {31'd0, done_c0}, 32'd1);
                checkOutput("c0_count", {16'd0, cnt_c0}, 32'd1);
                checkOutput("b_not_done", {31'd0, done_b}, 32'd0);
            end
        end
        checkOutput("b_done", {31'd0, done_b}, 32'd1);
        checkOutput("b_count", {16'd0, cnt_b}, 32'd2);
        checkOutput("b_busy", {31'd0, busy_b}, 32'd0);
        req_g = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("b_idle_valid", {31'd0, ifb.imem_resp_valid}, 32'd0);
        checkOutput("b_hold_data", ifb.imem_resp_bits_data, NOP);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
